// File: rtl/cp0_regs_pkg.sv
// cp0_regs_pkg: shared CP0 definitions.
//   - CP0 register addresses (BadVAddr, Count, Compare, Status, Cause, EPC)
//   - Exception cause codes written into Cause.ExcCode
//   - Status / Cause bit positions and the Status reset value
package cp0_regs_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

    // Status bit positions
    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_BEV   = 22;

    // Cause bit positions
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_TI     = 30;
    localparam int unsigned CA_BD     = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_regs_timer.sv
// cp0_timer: Count/Compare timer with timer-interrupt flag.
//   clk, resetn     : clock, asynchronous active-low reset
//   count_we_i      : load Count from wdata_i (also restarts the divider)
//   compare_we_i    : load Compare from wdata_i (also clears TI)
//   wdata_i         : write data
//   count_o         : current Count
//   compare_o       : current Compare
//   ti_o            : timer interrupt, set the cycle after Count==Compare
module cp0_timer
    import cp0_regs_pkg::*;
#(
    parameter int unsigned COUNT_DIV2 = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        div_q, div_d;
    logic        ti_q, ti_d;
    logic        tick;

    always_comb begin
        // With the divider enabled Count advances on the odd phase only
        tick      = (COUNT_DIV2 != 0) ? div_q : 1'b1;
        div_d     = (COUNT_DIV2 != 0) ? ~div_q : 1'b0;
        count_d   = count_q + {31'b0, tick};
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            div_q     <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS-style CP0 register file with exception/ERET control.
//   clk, resetn               : clock, asynchronous active-low reset
//   Exc_M, ExcCode_M          : synchronous exception and its cause code
//   PC_M, SL_Addr_M, BD_M     : M-stage PC, load/store address, delay-slot flag
//   Valid_M, Eret_M           : real instruction in M, ERET in M
//   Mtc0_We/Addr/Wdata        : CP0 register write
//   Mfc0_Addr, Mfc0_Rdata     : combinational CP0 read (pre-edge state)
//   Ext_Int                   : level-sensitive hardware interrupts
//   Flush, Redirect_PC        : pipeline squash and new fetch PC
//   EPC_out                   : current EPC
module cp0_regs
    import cp0_regs_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV2 = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Exc_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] SL_Addr_M,
    input  logic        BD_M,
    input  logic        Valid_M,
    input  logic        Eret_M,
    input  logic        Mtc0_We,
    input  logic [4:0]  Mtc0_Addr,
    input  logic [31:0] Mtc0_Wdata,
    input  logic [4:0]  Mfc0_Addr,
    output logic [31:0] Mfc0_Rdata,
    input  logic [5:0]  Ext_Int,
    output logic        Flush,
    output logic [31:0] Redirect_PC,
    output logic [31:0] EPC_out
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_pend, exc_take, eret_take, mtc0_take;
    logic [4:0]  exc_code;

    assign ip        = {ip_hw_q, ip_sw_q};
    assign int_pend  = Valid_M & ie_q & ~exl_q & (|(ip & im_q));
    assign exc_take  = int_pend | Exc_M;
    assign eret_take = Eret_M & ~exc_take;
    assign mtc0_take = Mtc0_We & ~exc_take & ~Eret_M;
    assign exc_code  = int_pend ? EXC_INT : ExcCode_M;

    cp0_timer #(
        .COUNT_DIV2(COUNT_DIV2)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_take && (Mtc0_Addr == CP0_COUNT)),
        .compare_we_i (mtc0_take && (Mtc0_Addr == CP0_COMPARE)),
        .wdata_i      (Mtc0_Wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (exc_take) begin
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                epc_d = BD_M ? (PC_M - 32'd4) : PC_M;
                bd_d  = BD_M;
            end
            exccode_d = exc_code;
            exl_d     = 1'b1;
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                badvaddr_d = (PC_M[1:0] != 2'b00) ? PC_M : SL_Addr_M;
        end else if (eret_take) begin
            exl_d = 1'b0;
        end else if (mtc0_take) begin
            case (Mtc0_Addr)
                CP0_STATUS: begin
                    im_d  = Mtc0_Wdata[ST_IM_LO +: 8];
                    exl_d = Mtc0_Wdata[ST_EXL];
                    ie_d  = Mtc0_Wdata[ST_IE];
                end
                CP0_CAUSE: ip_sw_d = Mtc0_Wdata[CA_IP_LO +: 2];
                CP0_EPC:   epc_d   = Mtc0_Wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            // Timer interrupt shares the IP7 line with Ext_Int[5]
            ip_hw_q    <= {ti | Ext_Int[5], Ext_Int[4:0]};
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        case (Mfc0_Addr)
            CP0_BADVADDR: Mfc0_Rdata = badvaddr_q;
            CP0_COUNT:    Mfc0_Rdata = count;
            CP0_COMPARE:  Mfc0_Rdata = compare;
            CP0_STATUS:   Mfc0_Rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            CP0_CAUSE:    Mfc0_Rdata = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
            CP0_EPC:      Mfc0_Rdata = epc_q;
            default:      Mfc0_Rdata = '0;
        endcase
    end

    // Flush is combinational from inputs, so it is gated by reset explicitly
    assign Flush       = resetn & (exc_take | eret_take);
    assign Redirect_PC = !resetn   ? '0 :
                         exc_take  ? EXC_VECTOR :
                         eret_take ? epc_q : '0;
    assign EPC_out     = epc_q;

endmodule

// File: tb/tb_cp0_regs.sv
module tb_cp0_regs;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int unsigned DIV = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Exc_M = 1'b0;
    logic [4:0]  ExcCode_M = '0;
    logic [31:0] PC_M = '0, SL_Addr_M = '0;
    logic        BD_M = 1'b0, Valid_M = 1'b0, Eret_M = 1'b0, Mtc0_We = 1'b0;
    logic [4:0]  Mtc0_Addr = '0, Mfc0_Addr = '0;
    logic [31:0] Mtc0_Wdata = '0;
    logic [31:0] Mfc0_Rdata;
    logic [5:0]  Ext_Int = '0;
    logic        Flush;
    logic [31:0] Redirect_PC, EPC_out;

    always #5 clk = ~clk;

    cp0_regs #(.EXC_VECTOR(VEC), .COUNT_DIV2(1)) dut (
        .clk(clk), .resetn(resetn), .Exc_M(Exc_M), .ExcCode_M(ExcCode_M),
        .PC_M(PC_M), .SL_Addr_M(SL_Addr_M), .BD_M(BD_M), .Valid_M(Valid_M),
        .Eret_M(Eret_M), .Mtc0_We(Mtc0_We), .Mtc0_Addr(Mtc0_Addr),
        .Mtc0_Wdata(Mtc0_Wdata), .Mfc0_Addr(Mfc0_Addr), .Mfc0_Rdata(Mfc0_Rdata),
        .Ext_Int(Ext_Int), .Flush(Flush), .Redirect_PC(Redirect_PC), .EPC_out(EPC_out)
    );

    typedef struct packed {
        logic        rst;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] sla;
        logic        bd;
        logic        valid;
        logic        eret;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  ext;
    } stim_t;

    typedef struct packed {
        logic        flush;
        logic [31:0] redir;
        logic [31:0] rdata;
        logic [31:0] epc;
    } exp_t;

    exp_t expq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    // Reference model: architectural state as plain fields; Count is
    // derived from the last loaded value plus elapsed cycles.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_bva, m_cmp, m_cbase;
    int unsigned m_ticks;

    task automatic m_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_code = '0;
        m_ipsw = '0; m_iphw = '0; m_epc = '0; m_bva = '0; m_cmp = '0;
        m_cbase = '0; m_ticks = 0;
    endtask

    function automatic logic [31:0] m_count();
        return m_cbase + 32'(m_ticks / DIV);
    endfunction

    function automatic logic m_int_pend(input logic valid);
        return valid && m_ie && !m_exl && (({m_iphw, m_ipsw} & m_im) != 8'h00);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count();
            5'd11:   return m_cmp;
            5'd12:   return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30)
                            | (32'({m_iphw, m_ipsw}) << 8) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Drive one cycle's inputs, queue the expected outputs, then advance
    // the model across the coming clock edge.
    task automatic apply(input stim_t s);
        exp_t e;
        logic is_int, is_exc, is_eret, ti_n;
        logic [5:0] iphw_n;
        logic [4:0] code;
        @(posedge clk);
        #1;
        resetn = s.rst; Exc_M = s.exc; ExcCode_M = s.code; PC_M = s.pc;
        SL_Addr_M = s.sla; BD_M = s.bd; Valid_M = s.valid; Eret_M = s.eret;
        Mtc0_We = s.we; Mtc0_Addr = s.waddr; Mtc0_Wdata = s.wdata;
        Mfc0_Addr = s.raddr; Ext_Int = s.ext;
        if (!s.rst) m_reset();
        is_int  = s.rst && m_int_pend(s.valid);
        is_exc  = is_int || (s.rst && s.exc);
        is_eret = s.rst && s.eret && !is_exc;
        e.flush = is_exc || is_eret;
        e.redir = is_exc ? VEC : (is_eret ? m_epc : 32'h0);
        e.rdata = m_read(s.raddr);
        e.epc   = m_epc;
        expq.push_back(e);
        if (s.rst) begin
            ti_n   = m_ti || (m_count() == m_cmp);
            iphw_n = {m_ti | s.ext[5], s.ext[4:0]};
            m_ticks++;
            if (is_exc) begin
                code = is_int ? 5'h00 : s.code;
                if (!m_exl) begin
                    m_epc = s.bd ? s.pc - 32'd4 : s.pc;
                    m_bd  = s.bd;
                end
                m_code = code;
                m_exl  = 1;
                if (code == 5'h04 || code == 5'h05)
                    m_bva = (s.pc[1:0] != 0) ? s.pc : s.sla;
            end else if (is_eret) begin
                m_exl = 0;
            end else if (s.we) begin
                case (s.waddr)
                    5'd9:  begin m_cbase = s.wdata; m_ticks = 0; end
                    5'd11: begin m_cmp = s.wdata; ti_n = 0; end
                    5'd12: begin m_im = s.wdata[15:8]; m_exl = s.wdata[1]; m_ie = s.wdata[0]; end
                    5'd13: m_ipsw = s.wdata[9:8];
                    5'd14: m_epc = s.wdata;
                    default: ;
                endcase
            end
            m_ti   = ti_n;
            m_iphw = iphw_n;
        end
    endtask

    // Monitor: outputs are valid every cycle; sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("flush", {31'b0, Flush}, {31'b0, e.flush});
                chk("redirect_pc", Redirect_PC, e.redir);
                chk("mfc0_rdata", Mfc0_Rdata, e.rdata);
                chk("epc_out", EPC_out, e.epc);
            end
        end
    end

    initial begin
        stim_t s;
        logic fired;
        logic [4:0] codes [6] = '{5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
        logic [4:0] waddrs[8] = '{5'd9, 5'd11, 5'd12, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
        logic [4:0] raddrs[8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd7};
        m_reset();

        // Reset, with an exception asserted to confirm Flush stays low
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rst = 0; s.exc = 1; s.code = 5'h08;
            apply(s);
            #2 chk("flush_in_reset", {31'b0, Flush}, 32'h0);
        end
        for (int i = 0; i < 10; i++) apply(idle());
        s = idle(); s.raddr = 5'd9; apply(s);
        #2 chk("count_after_10", Mfc0_Rdata, 32'd5);
        s = idle(); s.raddr = 5'd12; apply(s);
        #2 chk("status_reset", Mfc0_Rdata, 32'h0040_0000);

        // AdEL in a delay slot
        s = idle(); s.exc = 1; s.code = 5'h04; s.pc = 32'h8000_0102; s.bd = 1; s.valid = 1;
        apply(s);
        #2 chk("adel_flush", {31'b0, Flush}, 32'h1);
        chk("adel_vector", Redirect_PC, VEC);
        s = idle(); s.raddr = 5'd8; apply(s);
        #2 chk("badvaddr", Mfc0_Rdata, 32'h8000_0102);
        chk("epc_bd", EPC_out, 32'h8000_00FE);
        s = idle(); s.raddr = 5'd13; apply(s);
        #2 chk("cause_bd", {31'b0, Mfc0_Rdata[31]}, 32'h1);
        chk("cause_code_04", {27'b0, Mfc0_Rdata[6:2]}, 32'h04);
        s = idle(); s.raddr = 5'd12; apply(s);
        #2 chk("exl_set", {31'b0, Mfc0_Rdata[1]}, 32'h1);

        // Nested exception then ERET
        s = idle(); s.exc = 1; s.code = 5'h0c; s.pc = 32'h8000_1000; s.valid = 1;
        apply(s);
        s = idle(); s.raddr = 5'd13; apply(s);
        #2 chk("nested_code", {27'b0, Mfc0_Rdata[6:2]}, 32'h0c);
        chk("nested_epc", EPC_out, 32'h8000_00FE);
        s = idle(); s.eret = 1; s.valid = 1; apply(s);
        #2 chk("eret_flush", {31'b0, Flush}, 32'h1);
        chk("eret_target", Redirect_PC, 32'h8000_00FE);
        s = idle(); s.raddr = 5'd12; apply(s);
        #2 chk("exl_clear", {31'b0, Mfc0_Rdata[1]}, 32'h0);

        // Timer interrupt beats a coincident Exc_M
        s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'd20; apply(s);
        s = idle(); s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_8001; apply(s);
        fired = 0;
        for (int i = 0; i < 80 && !fired; i++) begin
            s = idle(); s.valid = 1; s.raddr = 5'd13; s.pc = 32'h8000_2000 + 32'(i * 4);
            if (m_int_pend(1'b1)) begin
                s.exc = 1; s.code = 5'h0a; fired = 1;
            end
            apply(s);
        end
        #2 chk("timer_int_fired", {31'b0, fired}, 32'h1);
        chk("timer_int_vector", Redirect_PC, VEC);
        s = idle(); s.raddr = 5'd13; apply(s);
        #2 chk("int_code_00", {27'b0, Mfc0_Rdata[6:2]}, 32'h00);

        // MTC0 dropped under exception; Count wrap; reset mid-flush
        s = idle(); s.exc = 1; s.code = 5'h08; s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_FF00;
        apply(s);
        s = idle(); s.raddr = 5'd12; apply(s);
        #2 chk("mtc0_dropped", Mfc0_Rdata, 32'h0040_8003);
        s = idle(); s.we = 1; s.waddr = 5'd9; s.wdata = 32'hFFFF_FFFF; apply(s);
        s = idle(); s.raddr = 5'd9; apply(s);
        #2 chk("count_max", Mfc0_Rdata, 32'hFFFF_FFFF);
        apply(s);
        apply(s);
        #2 chk("count_wrap", Mfc0_Rdata, 32'h0);
        s = idle(); s.exc = 1; s.code = 5'h09; apply(s);
        s.rst = 0; s.raddr = 5'd12; apply(s);
        #2 chk("flush_reset_mid", {31'b0, Flush}, 32'h0);
        chk("status_reset_mid", Mfc0_Rdata, 32'h0040_0000);
        s = idle(); s.rst = 0; s.raddr = 5'd13; apply(s);
        #2 chk("cause_reset_mid", Mfc0_Rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst   = ($urandom % 150) != 0;
            s.exc   = ($urandom % 8) == 0;
            s.code  = codes[$urandom % 6];
            s.pc    = {$urandom, 2'b00} | (($urandom % 4 == 0) ? 32'($urandom % 4) : 32'h0);
            s.sla   = $urandom;
            s.bd    = $urandom % 2;
            s.valid = ($urandom % 4) != 0;
            s.eret  = ($urandom % 8) == 0;
            s.we    = ($urandom % 3) == 0;
            s.waddr = waddrs[$urandom % 8];
            s.wdata = $urandom;
            if (s.waddr == 5'd11 && ($urandom % 2) == 1)
                s.wdata = m_count() + 32'($urandom % 6);
            if (s.waddr == 5'd12 && ($urandom % 2) == 1)
                s.wdata = ($urandom & 32'h0000_FF00) | 32'h1;
            s.raddr = raddrs[$urandom % 8];
            s.ext   = (($urandom % 5) == 0) ? 6'($urandom) : 6'h0;
            apply(s);
        end

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
